// File: rtl/seq_multiplier.sv
// Radix-2 shift-add unsigned multiplier: one multiplier bit per cycle.
// Latency: fixed WIDTH+1 edges from the accepting edge to the edge that samples done.
// Backpressure: none; start is honoured only in IDLE, otherwise dropped (never queued).
//
// Ports:
//   clk, rst_n        - rising-edge clock, asynchronous active-low reset
//   a_side, b_side    - unsigned multiplicand / multiplier, sampled on the accepting edge
//   start             - request a multiply (taken only while idle)
//   busy              - high in CALC and DONE
//   done              - one-cycle pulse while in DONE; mul_out/overflow valid from then on
//   mul_out, overflow - registered full-width product and "upper half nonzero" flag
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   a_side,
  input  logic [WIDTH-1:0]   b_side,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] mul_out,
  output logic               overflow
);

  // Counter holds WIDTH itself, so it needs ceil(log2(WIDTH+1)) bits.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [2*WIDTH-1:0] mcand;    // multiplicand, shifted left one place per iteration
  logic [WIDTH-1:0]   mplier;   // multiplier, shifted right; bit 0 is the current bit
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [CW-1:0]      cnt;      // iterations still to run, counts WIDTH down to 1
  logic               last_iter;

  assign acc_nxt   = mplier[0] ? (acc + mcand) : acc;
  assign last_iter = (cnt == CW'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (last_iter) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath. The result registers are written only on the final CALC edge,
  // using the combinational sum of that edge, so DONE already shows the product
  // and the outputs stay frozen for the whole of CALC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      mul_out  <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a_side};
            mplier <= b_side;
            acc    <= '0;
            cnt    <= CW'(WIDTH);
          end
        end
        CALC: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          if (last_iter) begin
            mul_out  <= acc_nxt;
            overflow <= |acc_nxt[2*WIDTH-1:WIDTH];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
